// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control block: FSM state type,
// stage-bit indices and the resolved per-stage stall vectors.
package cpu_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = (6'b1 << STG_PC) | (6'b1 << STG_IF) | (6'b1 << STG_ID);
  localparam logic [5:0] STALL_EX   = STALL_ID | (6'b1 << STG_EX);
  localparam logic [5:0] STALL_MEM  = STALL_EX | (6'b1 << STG_MEM);

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Runaway-stall watchdog: counts consecutive stalled cycles and emits a
// one-cycle timeout pulse every LIMIT cycles of an unbroken stall.
module pipe_ctrl_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic stalled_i,
  output logic timeout_o
);

  localparam logic [15:0] TERM = 16'(LIMIT - 1);

  logic [15:0] run_q;

  // Combinational so the pulse lands on the LIMIT-th stalled cycle itself.
  assign timeout_o = stalled_i && (run_q == TERM);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q <= 16'd0;
    end else if (!stalled_i || timeout_o) begin
      run_q <= 16'd0;
    end else begin
      run_q <= run_q + 16'd1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer. Optional runaway-stall watchdog is built
// when PIPE_CTRL_WDOG_EN is defined; otherwise timeout_o is tied low.
//
// state    | meaning
// ST_RUN   | normal flow; stall vector resolved MEM > EX > ID
// ST_FLUSH | flush_o high, new_pc_o valid, stall requests ignored
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        flush_req_i,
  input  logic [31:0] flush_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cnt_o,
  output logic        timeout_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDOG_LIMIT < 2 || WDOG_LIMIT > 65535) begin : g_bad_param
    $error("pipeline_ctrl: FLUSH_CYCLES or WDOG_LIMIT out of range");
  end

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q;
  logic [5:0]  stall;
  logic        stalled;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    stall   = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        if (flush_req_i) begin
          pc_d    = flush_pc_i;
          fcnt_d  = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else if (stallreq_mem_i) begin
          stall = STALL_MEM;
        end else if (stallreq_ex_i) begin
          stall = STALL_EX;
        end else if (stallreq_id_i) begin
          stall = STALL_ID;
        end
      end
      ST_FLUSH: begin
        // A fresh request restarts the window with the newest target.
        if (flush_req_i) begin
          pc_d   = flush_pc_i;
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q <= 4'd1) begin
          fcnt_d  = 4'd0;
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      fcnt_q  <= 4'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
    end
  end

  assign stalled = (stall != STALL_NONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 32'd0;
    end else if (stalled) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_o     = stall;
  assign flush_o     = (state_q == ST_FLUSH);
  assign new_pc_o    = pc_q;
  assign stall_cnt_o = cnt_q;

`ifdef PIPE_CTRL_WDOG_EN
  pipe_ctrl_wdog #(
    .LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .stalled_i (stalled),
    .timeout_o (timeout_o)
  );
`else
  assign timeout_o = 1'b0;
`endif

endmodule
